// File: rtl/audio_sample_frontend.sv
// Codec capture front-end: paced pop FSM, channel down-mix, gain with saturation, FWFT output FIFO.
// Define METER_EN to build the peak-hold level meter; without it, level is tied to 0.

// Generic first-word-fall-through FIFO.
// Latency: a push is visible at the head on the cycle after the write.
// Backpressure: pop only takes effect while head_vld_o; a push while full is illegal.
module asf_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       arst_ni,
    input  logic                       push_vld_i,
    input  logic [W-1:0]               push_dat_i,
    input  logic                       pop_i,
    output logic                       head_vld_o,
    output logic [W-1:0]               head_dat_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          pop;

    assign pop        = pop_i && head_vld_o;
    assign head_vld_o = (count_q != '0);
    assign head_dat_o = head_vld_o ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;

    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_vld_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)        rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_vld_i, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (arst_ni) assert (!(push_vld_i && count_q == CW'(DEPTH)));
    end
`endif
endmodule

// Pops one codec sample per handshake, mixes masked channels, scales and clamps into the FIFO.
// Latency: READ in cycle T -> FIFO write in T+2 -> head valid at T+3 (empty FIFO).
// Backpressure: no pop strobe is issued unless FIFO plus in-flight samples leave a free slot.
module audio_sample_frontend #(
    parameter int NUM_CH       = 2,
    parameter int IN_W         = 24,
    parameter int OUT_W        = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int METER_W      = 10,
    parameter int DECAY_PERIOD = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     src_ready,
    output logic                     src_read,
    input  logic [NUM_CH*IN_W-1:0]   src_data,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [2:0]               gain_shift,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sat_flag,
    input  logic                     sat_clr,
    output logic [METER_W-1:0]       level
);
    localparam int SUM_W  = IN_W + $clog2(NUM_CH) + 1;
    localparam int WIDE_W = SUM_W + 7;
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int OW     = CW + 1;
    localparam logic signed [WIDE_W-1:0] SAT_HI = {{(WIDE_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] SAT_LO = ~SAT_HI;

    if (NUM_CH < 1 || NUM_CH > 8 || OUT_W >= IN_W || FIFO_DEPTH < 4 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || METER_W > OUT_W - 1 || DECAY_PERIOD < 1) begin : g_bad_cfg
        $error("audio_sample_frontend: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;
    state_t state_q, state_d;

    logic [NUM_CH*IN_W-1:0]    s1_dat_q;
    logic [NUM_CH-1:0]         s1_mask_q;
    logic [2:0]                s1_gain_q, s2_gain_q;
    logic                      s1_vld_q, s2_vld_q;
    logic signed [SUM_W-1:0]   sum, s2_sum_q;
    logic signed [WIDE_W-1:0]  wide, shifted, scaled;
    logic signed [OUT_W-1:0]   sample;
    logic                      clamp;
    logic                      sat_flag_q, sat_flag_d;
    logic [CW-1:0]             fifo_count;
    logic [OW-1:0]             occupancy;

    assign occupancy = OW'(fifo_count) + OW'(s1_vld_q) + OW'(s2_vld_q);

    always_comb begin
        state_d  = state_q;
        src_read = 1'b0;
        unique case (state_q)
            IDLE: if (src_ready && occupancy < OW'(FIFO_DEPTH)) state_d = READ;
            READ: begin
                src_read = 1'b1;
                state_d  = HOLD;
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sum = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (s1_mask_q[c])
                sum = sum + {{(SUM_W-IN_W){s1_dat_q[c*IN_W+IN_W-1]}}, s1_dat_q[c*IN_W +: IN_W]};
        end
    end

    // Shift up in a wide enough word that no gain can wrap before the clamp.
    always_comb begin
        wide    = {{7{s2_sum_q[SUM_W-1]}}, s2_sum_q};
        shifted = wide <<< s2_gain_q;
        scaled  = shifted >>> (IN_W - OUT_W);
        clamp   = 1'b1;
        if (scaled > SAT_HI)      sample = {1'b0, {(OUT_W-1){1'b1}}};
        else if (scaled < SAT_LO) sample = {1'b1, {(OUT_W-1){1'b0}}};
        else begin
            sample = scaled[OUT_W-1:0];
            clamp  = 1'b0;
        end
    end

    assign sat_flag_d = (s2_vld_q && clamp) ? 1'b1 : (sat_clr ? 1'b0 : sat_flag_q);
    assign sat_flag   = sat_flag_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s1_dat_q   <= '0;
            s1_mask_q  <= '0;
            s1_gain_q  <= '0;
            s2_sum_q   <= '0;
            s2_gain_q  <= '0;
            sat_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_vld_q   <= src_read;
            s2_vld_q   <= s1_vld_q;
            sat_flag_q <= sat_flag_d;
            if (src_read) begin
                s1_dat_q  <= src_data;
                s1_mask_q <= ch_mask;
                s1_gain_q <= gain_shift;
            end
            if (s1_vld_q) begin
                s2_sum_q  <= sum;
                s2_gain_q <= s1_gain_q;
            end
        end
    end

    asf_fifo #(.W(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .arst_ni    (rst),
        .push_vld_i (s2_vld_q),
        .push_dat_i (sample),
        .pop_i      (out_ready),
        .head_vld_o (out_valid),
        .head_dat_o (out_data),
        .count_o    (fifo_count)
    );

`ifdef METER_EN
    localparam int DW = $clog2(DECAY_PERIOD + 1);
    localparam logic [OUT_W-2:0] ONE = 1;

    logic [OUT_W-2:0]   mag;
    logic [METER_W-1:0] m, level_q, level_d;
    logic [DW-1:0]      dcnt_q, dcnt_d;

    // The most negative sample has no positive twin; pin it to full scale.
    always_comb begin
        if (sample == {1'b1, {(OUT_W-1){1'b0}}}) mag = '1;
        else if (sample[OUT_W-1])                mag = ~sample[OUT_W-2:0] + ONE;
        else                                     mag = sample[OUT_W-2:0];
        m = METER_W'(mag >> (OUT_W - 1 - METER_W));
    end

    always_comb begin
        level_d = level_q;
        dcnt_d  = dcnt_q + DW'(1);
        if (s2_vld_q && m > level_q) begin
            level_d = m;
            dcnt_d  = '0;
        end else if (dcnt_q == DW'(DECAY_PERIOD - 1)) begin
            dcnt_d = '0;
            if (level_q != '0) level_d = level_q - METER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= '0;
            dcnt_q  <= '0;
        end else begin
            level_q <= level_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign level = level_q;
`else
    assign level = '0;
`endif
endmodule
